// File: rtl/accumulator_ctrl_pkg.sv
// Shared definitions for the accumulator tile sequencer: FSM encoding and
// default geometry, also consumed by the top-level TPU controller.
package accumulator_ctrl_pkg;

  localparam int unsigned ROWS_DEFAULT  = 2;
  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_ACCUM    = 3'd2,
    S_WAIT_BUF = 3'd3,
    S_FLUSH    = 3'd4
  } acc_state_e;

endpackage

// File: rtl/acc_drain_tracker.sv
// Tracks which of the two accumulator buffers hold a finished tile and hands
// them to the consumer in order through the drain_req/drain_done handshake.
module acc_drain_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic       set_en,
  input  logic       set_idx,
  input  logic       drain_done,
  output logic [1:0] full,
  output logic [1:0] full_after_c,
  output logic       drain_req_c,
  output logic       drain_buf_c
);

  logic       drain_ptr;
  logic       drain_fire;
  logic [1:0] full_nxt;

  assign drain_req_c = full[drain_ptr];
  assign drain_buf_c = drain_ptr;
  assign drain_fire  = drain_done & drain_req_c;

  // Drain release is applied before the set so a buffer freed this cycle is visible to the FSM
  always_comb begin
    full_after_c = full;
    if (drain_fire) begin
      full_after_c[drain_ptr] = 1'b0;
    end
    full_nxt = full_after_c | (set_en ? (2'b01 << set_idx) : 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!reset || init) begin
      full      <= 2'b00;
      drain_ptr <= 1'b0;
    end else begin
      full <= full_nxt;
      if (drain_fire) begin
        drain_ptr <= ~drain_ptr;
      end
    end
  end

endmodule

// File: rtl/accumulator_ctrl.sv
// Tile sequencer for the double-buffered accumulator: sums each output tile
// into one buffer while the other is drained by the downstream consumer.
module accumulator_ctrl
  import accumulator_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_k_tiles,
  input  logic [CNT_W-1:0] cfg_out_tiles,
  input  logic             mmu_valid,
  output logic             mmu_ready,
  output logic             acc_clear,
  output logic             acc_valid_in,
  output logic             acc_accumulate,
  output logic             acc_addr_sel,
  output logic             drain_req,
  output logic             drain_buf,
  input  logic             drain_done,
  output logic             busy,
  output logic             done,
  output logic             err_overrun
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  acc_state_e       state, state_nxt;
  logic [CNT_W-1:0] k_eff, out_tiles_q, tile_cnt, k_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [1:0]       full, full_after_c;
  logic             start_acc, row_last, k_last, last_tile, tile_done;

  assign mmu_ready    = (state == S_ACCUM);
  assign acc_valid_in = mmu_valid & mmu_ready;
  assign row_last     = (row_cnt == ROW_W'(ROWS - 1));
  assign k_last       = (k_cnt == k_eff - CNT_W'(1));
  assign last_tile    = (tile_cnt == out_tiles_q - CNT_W'(1));
  assign tile_done    = acc_valid_in & row_last & k_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    acc_clear = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_nxt = (out_tiles_q == '0) ? S_FLUSH : S_ACCUM;
      end
      S_ACCUM: begin
        if (tile_done) begin
          if (last_tile) begin
            state_nxt = S_FLUSH;
          end else if (full_after_c[~acc_addr_sel]) begin
            state_nxt = S_WAIT_BUF;
          end
        end
      end
      S_WAIT_BUF: begin
        if (!full[acc_addr_sel]) begin
          state_nxt = S_ACCUM;
        end
      end
      S_FLUSH: begin
        if (full == 2'b00) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row/K/tile counters; accumulate and buffer select only move after a K-tile's last row
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_eff          <= '0;
      out_tiles_q    <= '0;
      tile_cnt       <= '0;
      k_cnt          <= '0;
      row_cnt        <= '0;
      acc_accumulate <= 1'b0;
      acc_addr_sel   <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      if (start_acc) begin
        k_eff          <= (cfg_k_tiles == '0) ? CNT_W'(1) : cfg_k_tiles;
        out_tiles_q    <= cfg_out_tiles;
        tile_cnt       <= '0;
        k_cnt          <= '0;
        row_cnt        <= '0;
        acc_accumulate <= 1'b0;
        acc_addr_sel   <= 1'b0;
      end else if (acc_valid_in) begin
        if (row_last) begin
          row_cnt <= '0;
          if (k_last) begin
            k_cnt          <= '0;
            acc_accumulate <= 1'b0;
            tile_cnt       <= tile_cnt + CNT_W'(1);
            if (!last_tile) begin
              acc_addr_sel <= ~acc_addr_sel;
            end
          end else begin
            k_cnt          <= k_cnt + CNT_W'(1);
            acc_accumulate <= 1'b1;
          end
        end else begin
          row_cnt <= row_cnt + ROW_W'(1);
        end
      end

      if (start_acc) begin
        err_overrun <= 1'b0;
      end else if (mmu_valid && !mmu_ready) begin
        err_overrun <= 1'b1;
      end
    end
  end

  acc_drain_tracker u_drain (
    .clk          (clk),
    .reset        (reset),
    .init         (start_acc),
    .set_en       (tile_done),
    .set_idx      (acc_addr_sel),
    .drain_done   (drain_done),
    .full         (full),
    .full_after_c (full_after_c),
    .drain_req_c  (drain_req),
    .drain_buf_c  (drain_buf)
  );

endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Tile sequencer for the double-buffered accumulator. It takes a job descriptor (K partial-sum tiles per output tile, number of output tiles) and drives the accumulator's `clear`, `valid_in` gate, `accumulator_enable` and `addr_sel` so that each output tile is summed in one buffer while the other buffer is drained. It sits between the MMU row stream and the accumulator, and hands completed buffers to the downstream consumer through a req/done handshake.

## Interface
Parameters:
- `ROWS`, default 2: MMU result rows per K-tile; must be ≥ 1.
- `CNT_W`, default 8: width of the tile-count configuration fields.

Ports:
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle job launch pulse; ignored while `busy`.
- `cfg_k_tiles`  in  CNT_W  K-tiles per output tile; value 0 is treated as 1.
- `cfg_out_tiles`  in  CNT_W  output tiles in the job; value 0 means the job completes immediately.
- `mmu_valid`  in  1  an MMU row is present this cycle.
- `mmu_ready`  out  1  controller is accepting MMU rows (high only in ACCUM).
- `acc_clear`  out  1  one-cycle pulse to the accumulator `clear`.
- `acc_valid_in`  out  1  gated row-valid to the accumulator.
- `acc_accumulate`  out  1  to `accumulator_enable`: 0 = overwrite (first K-tile), 1 = add.
- `acc_addr_sel`  out  1  to `addr_sel`: buffer currently being summed.
- `drain_req`  out  1  a completed buffer is waiting for the consumer.
- `drain_buf`  out  1  index of the buffer to drain; valid while `drain_req` is high.
- `drain_done`  in  1  one-cycle pulse: consumer has finished with `drain_buf`.
- `busy`  out  1  a job is active.
- `done`  out  1  one-cycle pulse when the job ends.
- `err_overrun`  out  1  sticky flag: `mmu_valid` arrived while `mmu_ready` = 0. Cleared only by reset or `start`.

## Operation
- **State machine:** IDLE, CLEAR, ACCUM, WAIT_BUF, FLUSH.
- **IDLE:** on `start`, latch the configuration and zero the tile counter, K counter, row counter, `full[1:0]` and drain pointer. Clear `err_overrun`. Go to CLEAR.
- **CLEAR:** assert `acc_clear` for exactly one cycle and set `acc_addr_sel` = 0.
  - If `cfg_out_tiles` == 0, go to FLUSH.
  - Otherwise go to ACCUM.
- **ACCUM:**
  - `acc_valid_in` = `mmu_valid` & `mmu_ready`.
  - Each accepted row increments the row counter. When it reaches ROWS, the row counter resets and the K counter increments.
  - `acc_accumulate` = 0 while the K counter is 0, and 1 otherwise.
  - When the K counter reaches the effective `cfg_k_tiles`, the output tile is complete: set `full[acc_addr_sel]`, increment the tile counter and reset the K counter.
  - If that was the last tile, go to FLUSH.
  - Otherwise toggle `acc_addr_sel`. Go to WAIT_BUF if the new buffer's `full` bit is set; stay in ACCUM if it is clear.
- **WAIT_BUF:** `mmu_ready` = 0. Return to ACCUM once `full[acc_addr_sel]` clears.
- **Drain side (independent of state):**
  - `drain_req` = `full[drain_ptr]`; `drain_buf` = `drain_ptr`.
  - A `drain_done` while `drain_req` is high clears `full[drain_ptr]` and toggles `drain_ptr`.
  - A `drain_done` while `drain_req` is low is ignored.
- **FLUSH:** when `full` == 2'b00, pulse `done` and go to IDLE.
- **`busy`:** 1 in every state except IDLE.
- **Overrun:** `mmu_valid` with `mmu_ready` = 0 sets `err_overrun`. The row is dropped and never forwarded.

## Timing
- **Reset values:** all outputs 0. State IDLE, `full` = 0, drain pointer = 0, `acc_addr_sel` = 0.
- **Combinational paths:**
  - `acc_valid_in` follows `mmu_valid` with zero latency.
  - `mmu_ready`, `drain_req` and `drain_buf` are decoded from registered state only.
- **Registered outputs:** `acc_accumulate` and `acc_addr_sel` are held stable for every row of a K-tile. They change only in the cycle after the completing row.
- **Key latencies:**
  - `start` → `acc_clear` high on the next cycle.
  - First ACCUM cycle is the cycle after that.
  - Tile completion → `drain_req` high the next cycle.
- **Simultaneous tile completion and `drain_done`:** both updates apply in the same cycle. A buffer freed in that cycle lets the FSM go straight to ACCUM instead of WAIT_BUF.
- **`start` while `busy`:** no effect.
- **Reset mid-job:** `reset` low returns everything to reset values on the next edge, and no `done` pulse is issued.

## Structure
- A shared package holds the FSM state enum and the `ROWS`/`CNT_W` defaults, shared with the top-level TPU controller.
- One sub-module, `acc_drain_tracker`, owns `full[1:0]`, the drain pointer and the `drain_req`/`drain_done` logic. The FSM and counters stay in `accumulator_ctrl`.

## Test plan
- **Single pass:** `cfg_k_tiles` = 1, `cfg_out_tiles` = 1, 2 rows, `drain_done` 3 cycles after `drain_req` → `acc_clear` 1 cycle, `acc_accumulate` = 0, `drain_buf` = 0, `done` 1 cycle after `drain_done`.
- **K accumulation:** `cfg_k_tiles` = 3, `cfg_out_tiles` = 1, 6 rows → `acc_accumulate` 0,0,1,1,1,1 per row; `drain_req` after the 6th row.
- **Ping-pong:** `cfg_out_tiles` = 4, `cfg_k_tiles` = 1, continuous rows, immediate `drain_done` → `acc_addr_sel` 0,1,0,1; `drain_buf` sequence 0,1,0,1; no WAIT_BUF.
- **Backpressure:** `cfg_out_tiles` = 3 with `drain_done` withheld → after tile 2, `mmu_ready` = 0. An extra `mmu_valid` sets `err_overrun` and leaves `acc_valid_in` = 0. Releasing `drain_done` resumes tile 3 on buffer 0.
- **Edge cases:**
  - `cfg_out_tiles` = 0 → `done` 2 cycles after `start`.
  - `cfg_k_tiles` = 0 behaves as 1.
  - `start` while `busy` is ignored.
- **Reset mid-job:** `reset` = 0 during ACCUM with `full` = 2'b01 → next cycle all outputs are 0 and a later `start` runs cleanly.
